// File: rtl/mips_debug_pkg.sv
// Shared definitions for the MIPS debug controller: FSM states, UART command
// bytes, acknowledge code and the dump-section selector.
package mips_debug_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_CNT,
    ST_LOAD_BYTE,
    ST_LOAD_WRITE,
    ST_RUN,
    ST_STEP,
    ST_DUMP_ADDR,
    ST_DUMP_LATCH,
    ST_DUMP_SEND,
    ST_DUMP_WAIT,
    ST_ACK_SEND,
    ST_ACK_WAIT
  } state_t;

  typedef enum logic [1:0] {
    SEC_PC,
    SEC_REG,
    SEC_MEM
  } section_t;

  localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_RUN  = 8'h43;  // 'C'
  localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
  localparam logic [7:0] ACK_CODE = 8'h06;

endpackage

// File: rtl/dbg_word_serializer.sv
// Latches one word and sends it over the UART byte handshake, LSB first.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   load              1-cycle strobe: capture word and start sending
//   single            with load: send only the low byte
//   word              word to send
//   tx_done           UART finished the byte in flight
//   tx_data/tx_start  byte and 1-cycle start strobe towards the UART
//   done              1-cycle strobe after the last byte has completed
module dbg_word_serializer #(
  parameter int unsigned NBITS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             single,
  input  logic [NBITS-1:0] word,
  input  logic             tx_done,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  output logic             done
);

  logic [NBITS-1:0] word_q;
  logic [1:0]       byte_idx;
  logic             single_q;
  logic             active;
  logic             pending;
  logic             in_flight;

  // Issue a byte only when none is in flight; tx_done counts only while one is.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q    <= '0;
      byte_idx  <= 2'd0;
      single_q  <= 1'b0;
      active    <= 1'b0;
      pending   <= 1'b0;
      in_flight <= 1'b0;
      tx_data   <= 8'd0;
      tx_start  <= 1'b0;
      done      <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      if (load) begin
        word_q    <= word;
        byte_idx  <= 2'd0;
        single_q  <= single;
        active    <= 1'b1;
        pending   <= 1'b1;
        in_flight <= 1'b0;
      end else if (active) begin
        if (pending && !in_flight) begin
          tx_start  <= 1'b1;
          tx_data   <= word_q[{byte_idx, 3'b000} +: 8];
          in_flight <= 1'b1;
          pending   <= 1'b0;
        end else if (in_flight && tx_done) begin
          in_flight <= 1'b0;
          if (single_q || byte_idx == 2'd3) begin
            active <= 1'b0;
            done   <= 1'b1;
          end else begin
            byte_idx <= byte_idx + 2'd1;
            pending  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/mips_debug_ctrl.sv
// UART debug/sequencing controller for the MIPS pipeline: loads instruction
// memory, runs or single-steps the core, then dumps PC, registers and data memory.
// Ports:
//   basys_clk, basys_reset       clock, synchronous active-low reset
//   rx_data/rx_valid             received UART byte
//   tx_data/tx_start/tx_done     UART transmit handshake
//   mips_halt, mips_pc           core status
//   mips_enable, mips_rst        pipeline clock-enable, core reset (active high)
//   imem_we/imem_addr/imem_wdata instruction-memory write port
//   dbg_reg_addr/dbg_reg_data    register-file debug read port
//   dbg_mem_addr/dbg_mem_data    data-memory debug read port
module mips_debug_ctrl
  import mips_debug_pkg::*;
#(
  parameter int unsigned NBITS      = 32,
  parameter int unsigned CELDAS_REG = 32,
  parameter int unsigned CELDAS_M   = 70,
  parameter int unsigned IMEM_AW    = 8,
  parameter int unsigned REGS       = 5,
  localparam int unsigned MEM_AW    = $clog2(CELDAS_M)
) (
  input  logic               basys_clk,
  input  logic               basys_reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_done,
  input  logic               mips_halt,
  input  logic [NBITS-1:0]   mips_pc,
  output logic               mips_enable,
  output logic               mips_rst,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [NBITS-1:0]   imem_wdata,
  output logic [REGS-1:0]    dbg_reg_addr,
  input  logic [NBITS-1:0]   dbg_reg_data,
  output logic [MEM_AW-1:0]  dbg_mem_addr,
  input  logic [NBITS-1:0]   dbg_mem_data
);

  state_t           state;
  section_t         sec;
  logic [7:0]       word_cnt;
  logic [1:0]       byte_idx;
  logic [NBITS-1:0] dump_word_c;
  logic [NBITS-1:0] ser_word_c;
  logic             ser_load_c;
  logic             ser_single_c;
  logic             ser_done;

  // Word currently addressed by the dump section.
  always_comb begin
    dump_word_c = mips_pc;
    case (sec)
      SEC_REG: dump_word_c = dbg_reg_data;
      SEC_MEM: dump_word_c = dbg_mem_data;
      default: dump_word_c = mips_pc;
    endcase
  end

  assign ser_load_c   = (state == ST_DUMP_LATCH) || (state == ST_ACK_SEND);
  assign ser_single_c = (state == ST_ACK_SEND);
  assign ser_word_c   = ser_single_c ? NBITS'(ACK_CODE) : dump_word_c;

  dbg_word_serializer #(.NBITS(NBITS)) u_ser (
    .clk      (basys_clk),
    .rst_n    (basys_reset),
    .load     (ser_load_c),
    .single   (ser_single_c),
    .word     (ser_word_c),
    .tx_done  (tx_done),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .done     (ser_done)
  );

  // Sequencer; enable and write strobes default low each cycle.
  always_ff @(posedge basys_clk) begin
    if (!basys_reset) begin
      state        <= ST_IDLE;
      sec          <= SEC_PC;
      word_cnt     <= 8'd0;
      byte_idx     <= 2'd0;
      mips_enable  <= 1'b0;
      mips_rst     <= 1'b1;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      dbg_reg_addr <= '0;
      dbg_mem_addr <= '0;
    end else begin
      mips_enable <= 1'b0;
      imem_we     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            case (rx_data)
              CMD_LOAD: begin
                mips_rst <= 1'b1;
                state    <= ST_LOAD_CNT;
              end
              CMD_RUN:  state <= ST_RUN;
              CMD_STEP: state <= ST_STEP;
              default:  state <= ST_IDLE;
            endcase
          end
        end
        ST_LOAD_CNT: begin
          if (rx_valid) begin
            word_cnt  <= rx_data;
            imem_addr <= '0;
            byte_idx  <= 2'd0;
            state     <= (rx_data == 8'd0) ? ST_ACK_SEND : ST_LOAD_BYTE;
          end
        end
        ST_LOAD_BYTE: begin
          if (rx_valid) begin
            imem_wdata[{byte_idx, 3'b000} +: 8] <= rx_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              imem_we <= 1'b1;
              state   <= ST_LOAD_WRITE;
            end
          end
        end
        ST_LOAD_WRITE: begin
          // Address holds at the last word once the count is reached.
          if (imem_addr == IMEM_AW'(word_cnt - 8'd1)) begin
            state <= ST_ACK_SEND;
          end else begin
            imem_addr <= imem_addr + IMEM_AW'(1);
            state     <= ST_LOAD_BYTE;
          end
        end
        ST_RUN: begin
          if (mips_halt) begin
            sec          <= SEC_PC;
            dbg_reg_addr <= '0;
            dbg_mem_addr <= '0;
            state        <= ST_DUMP_ADDR;
          end else begin
            mips_enable <= 1'b1;
          end
        end
        ST_STEP: begin
          mips_enable  <= !mips_halt;
          sec          <= SEC_PC;
          dbg_reg_addr <= '0;
          dbg_mem_addr <= '0;
          state        <= ST_DUMP_ADDR;
        end
        ST_DUMP_ADDR:  state <= ST_DUMP_LATCH;
        ST_DUMP_LATCH: state <= ST_DUMP_SEND;
        ST_DUMP_SEND: begin
          if (ser_done) state <= ST_DUMP_WAIT;
        end
        ST_DUMP_WAIT: begin
          // Advance PC -> R0..Rn -> M0..Mn; indices stop at their last entry.
          state <= ST_DUMP_ADDR;
          case (sec)
            SEC_PC: sec <= SEC_REG;
            SEC_REG: begin
              if (dbg_reg_addr == REGS'(CELDAS_REG - 1)) sec <= SEC_MEM;
              else dbg_reg_addr <= dbg_reg_addr + REGS'(1);
            end
            default: begin
              if (dbg_mem_addr == MEM_AW'(CELDAS_M - 1)) state <= ST_IDLE;
              else dbg_mem_addr <= dbg_mem_addr + MEM_AW'(1);
            end
          endcase
        end
        ST_ACK_SEND: state <= ST_ACK_WAIT;
        ST_ACK_WAIT: begin
          // ACK only follows a load, so the core leaves reset here.
          if (ser_done) begin
            mips_rst <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// Scoreboard bench for mips_debug_ctrl: stimulus pushes expected UART bytes and
// imem writes into queues; a negedge monitor models the UART, pops and compares.
module tb_mips_debug_ctrl;

  logic        basys_clk = 1'b0;
  logic        basys_reset = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done = 1'b0;
  logic        mips_halt;
  logic [31:0] mips_pc;
  logic        mips_enable;
  logic        mips_rst;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [4:0]  dbg_reg_addr;
  logic [31:0] dbg_reg_data;
  logic [6:0]  dbg_mem_addr;
  logic [31:0] dbg_mem_data;

  int checks = 0;
  int errors = 0;
  int en_count = 0;
  int en_base = 0;
  int tx_count = 0;
  int dly = 0;
  logic busy = 1'b0;
  logic halt_force = 1'b0;
  logic halt_armed = 1'b0;
  int halt_after = 0;
  logic [31:0] pc_base = 32'd0;
  logic [31:0] regs[32];
  logic [31:0] mem[128];
  logic [31:0] ld_words[8];
  logic [7:0]  exp_tx[$];
  logic [39:0] exp_we[$];

  localparam int DUMP_BYTES = 4 * (1 + 32 + 70);

  mips_debug_ctrl dut (
    .basys_clk    (basys_clk),
    .basys_reset  (basys_reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_done      (tx_done),
    .mips_halt    (mips_halt),
    .mips_pc      (mips_pc),
    .mips_enable  (mips_enable),
    .mips_rst     (mips_rst),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .dbg_reg_addr (dbg_reg_addr),
    .dbg_reg_data (dbg_reg_data),
    .dbg_mem_addr (dbg_mem_addr),
    .dbg_mem_data (dbg_mem_data)
  );

  initial forever #5 basys_clk = ~basys_clk;

  // Core model: PC advances one word per enable cycle; halt by level or after N enables.
  assign mips_pc      = pc_base + 32'(4 * (en_count - en_base));
  assign mips_halt    = halt_force | (halt_armed & ((en_count - en_base) >= halt_after));
  assign dbg_reg_data = regs[dbg_reg_addr];
  assign dbg_mem_data = mem[dbg_mem_addr];

  function automatic void check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // UART model + monitor.
  initial forever begin
    @(negedge basys_clk);
    if (!basys_reset) begin
      busy    = 1'b0;
      tx_done = 1'b0;
    end else begin
      if (tx_done) begin
        tx_done = 1'b0;
        busy    = 1'b0;
      end else if (busy) begin
        if (dly == 0) tx_done = 1'b1;
        else dly--;
      end
      if (tx_start) begin
        check("tx_start while byte in flight", 40'(busy), 40'd0);
        busy = 1'b1;
        dly  = $urandom_range(0, 3);
        tx_count++;
        if (exp_tx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected tx byte: got %h, expected none", tx_data);
        end else begin
          check("tx byte", 40'(tx_data), 40'(exp_tx.pop_front()));
        end
      end
      if (mips_enable) en_count++;
      if (imem_we) begin
        if (exp_we.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected imem_we: got %h/%h, expected none", imem_addr, imem_wdata);
        end else begin
          check("imem write addr/data", {imem_addr, imem_wdata}, exp_we.pop_front());
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge basys_clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge basys_clk);
    rx_valid = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge basys_clk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_tx.size() != 0 || exp_we.size() != 0 || busy) && n < 20000) begin
      @(negedge basys_clk);
      n++;
    end
    repeat (30) @(negedge basys_clk);
    check({name, " pending items"}, 40'(exp_tx.size() + exp_we.size()), 40'd0);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) exp_tx.push_back(w[8*b +: 8]);
  endtask

  task automatic push_dump(input logic [31:0] pc);
    push_word(pc);
    for (int r = 0; r < 32; r++) push_word(regs[r]);
    for (int m = 0; m < 70; m++) push_word(mem[m]);
  endtask

  task automatic rand_state();
    for (int r = 0; r < 32; r++) regs[r] = $urandom;
    regs[0] = 32'd0;
    for (int m = 0; m < 128; m++) mem[m] = $urandom;
    pc_base = {$urandom_range(0, 1000), 2'b00};
  endtask

  task automatic do_load(input int n, input string name);
    for (int k = 0; k < n; k++) exp_we.push_back({8'(k), ld_words[k]});
    exp_tx.push_back(8'h06);
    send_byte(8'h4C);
    send_byte(8'(n));
    for (int k = 0; k < n; k++)
      for (int b = 0; b < 4; b++) send_byte(ld_words[k][8*b +: 8]);
    drain(name);
    check({name, " mips_rst after load"}, 40'(mips_rst), 40'd0);
  endtask

  task automatic do_cmd(input logic [7:0] cmd, input int exp_en, input string name);
    en_base = en_count;
    push_dump(pc_base + 32'(4 * exp_en));
    send_byte(cmd);
    drain(name);
    check({name, " enable cycles"}, 40'(en_count - en_base), 40'(exp_en));
  endtask

  initial begin
    int t0;
    int e0;
    int n;
    int nw;
    rand_state();
    repeat (3) @(negedge basys_clk);
    check("reset tx_start", 40'(tx_start), 40'd0);
    check("reset tx_data", 40'(tx_data), 40'd0);
    check("reset mips_enable", 40'(mips_enable), 40'd0);
    check("reset mips_rst", 40'(mips_rst), 40'd1);
    check("reset imem_we", 40'(imem_we), 40'd0);
    check("reset imem_addr", 40'(imem_addr), 40'd0);
    check("reset dbg_reg_addr", 40'(dbg_reg_addr), 40'd0);
    check("reset dbg_mem_addr", 40'(dbg_mem_addr), 40'd0);
    basys_reset = 1'b1;
    repeat (2) @(negedge basys_clk);

    // Fixed two-word load.
    ld_words[0] = 32'h12345678;
    ld_words[1] = 32'hDEADBEEF;
    do_load(2, "load2");

    // Randomized loads.
    for (int i = 0; i < 2; i++) begin
      nw = $urandom_range(1, 8);
      for (int k = 0; k < 8; k++) ld_words[k] = $urandom;
      do_load(nw, "load_rand");
    end

    // Empty load and an unknown byte.
    do_load(0, "load0");
    t0 = tx_count;
    e0 = en_count;
    send_byte(8'h58);
    repeat (40) @(negedge basys_clk);
    check("X no tx", 40'(tx_count - t0), 40'd0);
    check("X no enable", 40'(en_count - e0), 40'd0);

    // Single step from PC 0 with R1 = 5.
    rand_state();
    pc_base = 32'd0;
    regs[1] = 32'd5;
    do_cmd(8'h53, 1, "step");

    // Run until halt after 20 enables, then a random halt point.
    rand_state();
    halt_after = 20;
    halt_armed = 1'b1;
    t0 = tx_count;
    do_cmd(8'h43, 20, "run20");
    check("run20 byte count", 40'(tx_count - t0), 40'(DUMP_BYTES));
    halt_armed = 1'b0;
    rand_state();
    halt_after = $urandom_range(1, 40);
    halt_armed = 1'b1;
    do_cmd(8'h43, halt_after, "run_rand");
    halt_armed = 1'b0;

    // Step while halted: no enable cycle.
    rand_state();
    halt_force = 1'b1;
    do_cmd(8'h53, 0, "step_halted");

    // Run with halt already high; commands during the dump are dropped.
    rand_state();
    en_base = en_count;
    t0 = tx_count;
    push_dump(pc_base);
    send_byte(8'h43);
    send_byte(8'h53);
    send_byte(8'h4C);
    send_byte(8'h43);
    send_byte(8'h02);
    drain("run_halted");
    halt_force = 1'b0;
    repeat (100) @(negedge basys_clk);
    check("run_halted enable cycles", 40'(en_count - en_base), 40'd0);
    check("run_halted byte count", 40'(tx_count - t0), 40'(DUMP_BYTES));

    // Reset in the middle of a dump.
    rand_state();
    en_base = en_count;
    t0 = tx_count;
    push_dump(pc_base + 32'd4);
    send_byte(8'h53);
    n = 0;
    while ((tx_count - t0) < 10 && n < 5000) begin
      @(negedge basys_clk);
      n++;
    end
    check("mid-dump reached", 40'(n < 5000), 40'd1);
    basys_reset = 1'b0;
    @(negedge basys_clk);
    check("mid reset tx_start", 40'(tx_start), 40'd0);
    check("mid reset tx_data", 40'(tx_data), 40'd0);
    check("mid reset mips_enable", 40'(mips_enable), 40'd0);
    check("mid reset mips_rst", 40'(mips_rst), 40'd1);
    exp_tx.delete();
    repeat (2) @(negedge basys_clk);
    basys_reset = 1'b1;
    t0 = tx_count;
    repeat (50) @(negedge basys_clk);
    check("no tx after reset", 40'(tx_count - t0), 40'd0);
    do_load(0, "post_reset_load0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
